// File: rtl/clock_comparison_pkg.sv
// Shared definitions for the clockComparison AXI4-Lite register block:
// word map, response codes, channel FSM states and a byte-lane merge helper.
package clock_comparison_pkg;

    localparam int NUM_WORDS = 8;
    localparam int NUM_CTRL  = 4;
    localparam int ADDR_LSB  = 2;
    localparam int SLOT_W    = $clog2(NUM_WORDS);

    // Word slots (byte offset = slot * 4)
    localparam logic [SLOT_W-1:0] CTRL0 = 3'd0;
    localparam logic [SLOT_W-1:0] CTRL1 = 3'd1;
    localparam logic [SLOT_W-1:0] CTRL2 = 3'd2;
    localparam logic [SLOT_W-1:0] CTRL3 = 3'd3;
    localparam logic [SLOT_W-1:0] STAT0 = 3'd4;
    localparam logic [SLOT_W-1:0] STAT1 = 3'd5;
    localparam logic [SLOT_W-1:0] STAT2 = 3'd6;
    localparam logic [SLOT_W-1:0] STAT3 = 3'd7;

    typedef enum logic [1:0] {
        RESP_OKAY   = 2'b00,
        RESP_SLVERR = 2'b10
    } axi_resp_e;

    typedef enum logic [1:0] {
        WR_IDLE,
        WR_HAVE_AW,
        WR_HAVE_W,
        WR_RESP
    } wr_state_e;

    typedef enum logic {
        RD_IDLE,
        RD_VALID
    } rd_state_e;

    function automatic logic [31:0] apply_wstrb(
        input logic [31:0] old_val,
        input logic [31:0] new_val,
        input logic [3:0]  strb
    );
        logic [31:0] res;
        res = old_val;
        for (int b = 0; b < 4; b++) begin
            if (strb[b]) res[8*b +: 8] = new_val[8*b +: 8];
        end
        return res;
    endfunction

endpackage

// File: rtl/clock_comparison_axil_slave.sv
// AXI4-Lite responder holding the clockComparison register file.
// Ports: ACLK/ARESET; S_AXI_AW*/W*/B* write path; S_AXI_AR*/R* read path;
// ctrl_regs = RW words 0..3 to the core; status_in = RO words 4..7 from it.
module clock_comparison_axil_slave
    import clock_comparison_pkg::*;
#(
    parameter int          C_S_AXI_DATA_WIDTH = 32,
    parameter int          C_S_AXI_ADDR_WIDTH = 5,
    parameter logic [31:0] RW_RESET_VAL       = 32'h0
) (
    input  logic                          ACLK,
    input  logic                          ARESET,
    input  logic [C_S_AXI_ADDR_WIDTH-1:0] S_AXI_AWADDR,
    input  logic [2:0]                    S_AXI_AWPROT,
    input  logic                          S_AXI_AWVALID,
    output logic                          S_AXI_AWREADY,
    input  logic [C_S_AXI_DATA_WIDTH-1:0] S_AXI_WDATA,
    input  logic [3:0]                    S_AXI_WSTRB,
    input  logic                          S_AXI_WVALID,
    output logic                          S_AXI_WREADY,
    output logic [1:0]                    S_AXI_BRESP,
    output logic                          S_AXI_BVALID,
    input  logic                          S_AXI_BREADY,
    input  logic [C_S_AXI_ADDR_WIDTH-1:0] S_AXI_ARADDR,
    input  logic [2:0]                    S_AXI_ARPROT,
    input  logic                          S_AXI_ARVALID,
    output logic                          S_AXI_ARREADY,
    output logic [C_S_AXI_DATA_WIDTH-1:0] S_AXI_RDATA,
    output logic [1:0]                    S_AXI_RRESP,
    output logic                          S_AXI_RVALID,
    input  logic                          S_AXI_RREADY,
    output logic [NUM_CTRL-1:0][C_S_AXI_DATA_WIDTH-1:0] ctrl_regs,
    input  logic [NUM_CTRL-1:0][C_S_AXI_DATA_WIDTH-1:0] status_in
);

    wr_state_e         wr_state;
    rd_state_e         rd_state;
    logic [SLOT_W-1:0] aw_slot_q;
    logic [31:0]       w_data_q;
    logic [3:0]        w_strb_q;

    logic              aw_hs;
    logic              w_hs;
    logic              ar_hs;
    logic              wr_fire;
    logic [SLOT_W-1:0] wr_slot;
    logic [31:0]       wr_data;
    logic [3:0]        wr_strb;
    logic [SLOT_W-1:0] aw_slot;
    logic [SLOT_W-1:0] ar_slot;
    logic [31:0]       rd_word;

    // Protection bits and byte offset within a word carry no meaning here
    wire unused_ok = ^{S_AXI_AWPROT, S_AXI_ARPROT,
                       S_AXI_AWADDR[ADDR_LSB-1:0],
                       S_AXI_ARADDR[ADDR_LSB-1:0]};

    assign aw_hs   = S_AXI_AWVALID && S_AXI_AWREADY;
    assign w_hs    = S_AXI_WVALID && S_AXI_WREADY;
    assign ar_hs   = S_AXI_ARVALID && S_AXI_ARREADY;
    assign aw_slot = S_AXI_AWADDR[ADDR_LSB +: SLOT_W];
    assign ar_slot = S_AXI_ARADDR[ADDR_LSB +: SLOT_W];

    assign S_AXI_RRESP = RESP_OKAY;

    // Commit happens on the edge where the second half of the pair arrives;
    // the operands come from the live bus for that half, the hold for the other.
    always_comb begin
        wr_fire = 1'b0;
        wr_slot = aw_slot_q;
        wr_data = w_data_q;
        wr_strb = w_strb_q;
        unique case (wr_state)
            WR_IDLE: begin
                wr_fire = aw_hs && w_hs;
                wr_slot = aw_slot;
                wr_data = S_AXI_WDATA;
                wr_strb = S_AXI_WSTRB;
            end
            WR_HAVE_AW: begin
                wr_fire = w_hs;
                wr_data = S_AXI_WDATA;
                wr_strb = S_AXI_WSTRB;
            end
            WR_HAVE_W: begin
                wr_fire = aw_hs;
                wr_slot = aw_slot;
            end
            default: ;
        endcase
    end

    always_ff @(posedge ACLK or posedge ARESET) begin
        if (ARESET) begin
            wr_state      <= WR_IDLE;
            S_AXI_AWREADY <= 1'b0;
            S_AXI_WREADY  <= 1'b0;
            S_AXI_BVALID  <= 1'b0;
            S_AXI_BRESP   <= RESP_OKAY;
            aw_slot_q     <= '0;
            w_data_q      <= '0;
            w_strb_q      <= '0;
        end else begin
            if (wr_fire) begin
                wr_state      <= WR_RESP;
                S_AXI_AWREADY <= 1'b0;
                S_AXI_WREADY  <= 1'b0;
                S_AXI_BVALID  <= 1'b1;
                S_AXI_BRESP   <= wr_slot[SLOT_W-1] ? RESP_SLVERR : RESP_OKAY;
            end else begin
                unique case (wr_state)
                    WR_IDLE: begin
                        S_AXI_AWREADY <= 1'b1;
                        S_AXI_WREADY  <= 1'b1;
                        if (aw_hs) begin
                            wr_state      <= WR_HAVE_AW;
                            aw_slot_q     <= aw_slot;
                            S_AXI_AWREADY <= 1'b0;
                        end else if (w_hs) begin
                            wr_state     <= WR_HAVE_W;
                            w_data_q     <= S_AXI_WDATA;
                            w_strb_q     <= S_AXI_WSTRB;
                            S_AXI_WREADY <= 1'b0;
                        end
                    end
                    WR_RESP: begin
                        if (S_AXI_BREADY) begin
                            wr_state      <= WR_IDLE;
                            S_AXI_BVALID  <= 1'b0;
                            S_AXI_AWREADY <= 1'b1;
                            S_AXI_WREADY  <= 1'b1;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

    // Status slots have bit 2 set; writes there are discarded
    always_ff @(posedge ACLK or posedge ARESET) begin
        if (ARESET) begin
            for (int i = 0; i < NUM_CTRL; i++) ctrl_regs[i] <= RW_RESET_VAL;
        end else if (wr_fire && !wr_slot[SLOT_W-1]) begin
            ctrl_regs[wr_slot[1:0]] <=
                apply_wstrb(ctrl_regs[wr_slot[1:0]], wr_data, wr_strb);
        end
    end

    always_comb begin
        rd_word = '0;
        unique case (ar_slot)
            CTRL0: rd_word = ctrl_regs[0];
            CTRL1: rd_word = ctrl_regs[1];
            CTRL2: rd_word = ctrl_regs[2];
            CTRL3: rd_word = ctrl_regs[3];
            STAT0: rd_word = status_in[0];
            STAT1: rd_word = status_in[1];
            STAT2: rd_word = status_in[2];
            STAT3: rd_word = status_in[3];
            default: ;
        endcase
    end

    // ctrl_regs is sampled before this edge's write lands: read sees old value
    always_ff @(posedge ACLK or posedge ARESET) begin
        if (ARESET) begin
            rd_state      <= RD_IDLE;
            S_AXI_ARREADY <= 1'b0;
            S_AXI_RVALID  <= 1'b0;
            S_AXI_RDATA   <= '0;
        end else begin
            unique case (rd_state)
                RD_IDLE: begin
                    S_AXI_ARREADY <= 1'b1;
                    if (ar_hs) begin
                        rd_state      <= RD_VALID;
                        S_AXI_RDATA   <= rd_word;
                        S_AXI_RVALID  <= 1'b1;
                        S_AXI_ARREADY <= 1'b0;
                    end
                end
                RD_VALID: begin
                    if (S_AXI_RREADY) begin
                        rd_state      <= RD_IDLE;
                        S_AXI_RVALID  <= 1'b0;
                        S_AXI_ARREADY <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_clock_comparison_axil_slave.sv
// Directed bench for clock_comparison_axil_slave: vector table for
// single transactions plus hand-written multi-cycle sequences.
module tb_clock_comparison_axil_slave;

    logic              ACLK = 1'b0;
    logic              ARESET;
    logic [4:0]        S_AXI_AWADDR;
    logic [2:0]        S_AXI_AWPROT;
    logic              S_AXI_AWVALID;
    logic              S_AXI_AWREADY;
    logic [31:0]       S_AXI_WDATA;
    logic [3:0]        S_AXI_WSTRB;
    logic              S_AXI_WVALID;
    logic              S_AXI_WREADY;
    logic [1:0]        S_AXI_BRESP;
    logic              S_AXI_BVALID;
    logic              S_AXI_BREADY;
    logic [4:0]        S_AXI_ARADDR;
    logic [2:0]        S_AXI_ARPROT;
    logic              S_AXI_ARVALID;
    logic              S_AXI_ARREADY;
    logic [31:0]       S_AXI_RDATA;
    logic [1:0]        S_AXI_RRESP;
    logic              S_AXI_RVALID;
    logic              S_AXI_RREADY;
    logic [3:0][31:0]  ctrl_regs;
    logic [3:0][31:0]  status_in;

    clock_comparison_axil_slave dut (
        .ACLK          (ACLK),
        .ARESET        (ARESET),
        .S_AXI_AWADDR  (S_AXI_AWADDR),
        .S_AXI_AWPROT  (S_AXI_AWPROT),
        .S_AXI_AWVALID (S_AXI_AWVALID),
        .S_AXI_AWREADY (S_AXI_AWREADY),
        .S_AXI_WDATA   (S_AXI_WDATA),
        .S_AXI_WSTRB   (S_AXI_WSTRB),
        .S_AXI_WVALID  (S_AXI_WVALID),
        .S_AXI_WREADY  (S_AXI_WREADY),
        .S_AXI_BRESP   (S_AXI_BRESP),
        .S_AXI_BVALID  (S_AXI_BVALID),
        .S_AXI_BREADY  (S_AXI_BREADY),
        .S_AXI_ARADDR  (S_AXI_ARADDR),
        .S_AXI_ARPROT  (S_AXI_ARPROT),
        .S_AXI_ARVALID (S_AXI_ARVALID),
        .S_AXI_ARREADY (S_AXI_ARREADY),
        .S_AXI_RDATA   (S_AXI_RDATA),
        .S_AXI_RRESP   (S_AXI_RRESP),
        .S_AXI_RVALID  (S_AXI_RVALID),
        .S_AXI_RREADY  (S_AXI_RREADY),
        .ctrl_regs     (ctrl_regs),
        .status_in     (status_in)
    );

    always #5 ACLK = ~ACLK;

    int n_checks = 0;
    int n_fail   = 0;

    typedef struct {
        bit          is_wr;
        logic [4:0]  addr;
        logic [31:0] data;
        logic [3:0]  strb;
        logic [1:0]  exp_resp;
        logic [31:0] exp_rdata;
    } vec_t;

    vec_t vecs [18];

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic timeout(input string name);
        n_checks++;
        n_fail++;
        $display("FAIL %s: timeout waiting for handshake", name);
    endtask

    task automatic do_write(input logic [4:0] a, input logic [31:0] d,
                            input logic [3:0] s, input int hold,
                            output logic [1:0] resp, output bit stable);
        bit aw_done = 0;
        bit w_done = 0;
        bit aw_go;
        bit w_go;
        int n = 0;
        resp = 2'bxx;
        stable = 0;
        @(negedge ACLK);
        S_AXI_AWADDR = a; S_AXI_AWVALID = 1;
        S_AXI_WDATA = d; S_AXI_WSTRB = s; S_AXI_WVALID = 1;
        while (!(aw_done && w_done) && n < 20) begin
            aw_go = S_AXI_AWVALID && S_AXI_AWREADY;
            w_go  = S_AXI_WVALID && S_AXI_WREADY;
            @(posedge ACLK); #1;
            if (aw_go) begin S_AXI_AWVALID = 0; aw_done = 1; end
            if (w_go)  begin S_AXI_WVALID = 0;  w_done = 1;  end
            n++;
            if (!(aw_done && w_done)) @(negedge ACLK);
        end
        S_AXI_AWVALID = 0; S_AXI_WVALID = 0;
        if (!(aw_done && w_done)) begin timeout("write_addr_data"); return; end
        n = 0;
        @(negedge ACLK);
        while (!S_AXI_BVALID && n < 20) begin @(negedge ACLK); n++; end
        if (!S_AXI_BVALID) begin timeout("write_resp"); return; end
        resp = S_AXI_BRESP;
        stable = 1;
        repeat (hold) begin
            @(negedge ACLK);
            if (!S_AXI_BVALID || S_AXI_BRESP !== resp ||
                S_AXI_AWREADY || S_AXI_WREADY) stable = 0;
        end
        S_AXI_BREADY = 1;
        @(posedge ACLK); #1;
        S_AXI_BREADY = 0;
    endtask

    task automatic do_read(input logic [4:0] a, input int hold,
                           output logic [31:0] data, output logic [1:0] resp,
                           output bit stable);
        bit done = 0;
        int n = 0;
        data = 'x; resp = 2'bxx; stable = 0;
        @(negedge ACLK);
        S_AXI_ARADDR = a; S_AXI_ARVALID = 1;
        while (!done && n < 20) begin
            done = S_AXI_ARREADY;
            @(posedge ACLK); #1;
            n++;
            if (!done) @(negedge ACLK);
        end
        S_AXI_ARVALID = 0;
        if (!done) begin timeout("read_addr"); return; end
        n = 0;
        @(negedge ACLK);
        while (!S_AXI_RVALID && n < 20) begin @(negedge ACLK); n++; end
        if (!S_AXI_RVALID) begin timeout("read_data"); return; end
        data = S_AXI_RDATA;
        resp = S_AXI_RRESP;
        stable = 1;
        repeat (hold) begin
            @(negedge ACLK);
            if (!S_AXI_RVALID || S_AXI_RDATA !== data || S_AXI_ARREADY)
                stable = 0;
        end
        S_AXI_RREADY = 1;
        @(posedge ACLK); #1;
        S_AXI_RREADY = 0;
    endtask

    initial begin
        logic [1:0]  resp;
        logic [31:0] rdata;
        bit          st;
        bit          seen;
        int          cnt;

        vecs[0]  = '{1'b1, 5'h00, 32'h1,        4'hF, 2'b00, 32'h0};
        vecs[1]  = '{1'b1, 5'h04, 32'h2,        4'hF, 2'b00, 32'h0};
        vecs[2]  = '{1'b1, 5'h08, 32'h3,        4'hF, 2'b00, 32'h0};
        vecs[3]  = '{1'b1, 5'h0C, 32'h4,        4'hF, 2'b00, 32'h0};
        vecs[4]  = '{1'b0, 5'h00, 32'h0,        4'h0, 2'b00, 32'h1};
        vecs[5]  = '{1'b0, 5'h04, 32'h0,        4'h0, 2'b00, 32'h2};
        vecs[6]  = '{1'b0, 5'h08, 32'h0,        4'h0, 2'b00, 32'h3};
        vecs[7]  = '{1'b0, 5'h0C, 32'h0,        4'h0, 2'b00, 32'h4};
        vecs[8]  = '{1'b1, 5'h10, 32'hFFFFFFFF, 4'hF, 2'b10, 32'h0};
        vecs[9]  = '{1'b0, 5'h10, 32'h0,        4'h0, 2'b00, 32'hDEADBEEF};
        vecs[10] = '{1'b0, 5'h1C, 32'h0,        4'h0, 2'b00, 32'h0BADC0DE};
        vecs[11] = '{1'b1, 5'h00, 32'h0,        4'hF, 2'b00, 32'h0};
        vecs[12] = '{1'b1, 5'h00, 32'hFFFFFFFF, 4'h5, 2'b00, 32'h0};
        vecs[13] = '{1'b0, 5'h00, 32'h0,        4'h0, 2'b00, 32'h00FF00FF};
        vecs[14] = '{1'b1, 5'h08, 32'hFFFFFFFF, 4'h0, 2'b00, 32'h0};
        vecs[15] = '{1'b0, 5'h08, 32'h0,        4'h0, 2'b00, 32'h3};
        vecs[16] = '{1'b1, 5'h0D, 32'h44,       4'hF, 2'b00, 32'h0};
        vecs[17] = '{1'b0, 5'h0E, 32'h0,        4'h0, 2'b00, 32'h44};

        status_in[0] = 32'hDEADBEEF;
        status_in[1] = 32'h12345678;
        status_in[2] = 32'hCAFEF00D;
        status_in[3] = 32'h0BADC0DE;
        ARESET = 1;
        S_AXI_AWADDR = 0; S_AXI_AWPROT = 0; S_AXI_AWVALID = 0;
        S_AXI_WDATA = 0; S_AXI_WSTRB = 0; S_AXI_WVALID = 0;
        S_AXI_BREADY = 0;
        S_AXI_ARADDR = 0; S_AXI_ARPROT = 0; S_AXI_ARVALID = 0;
        S_AXI_RREADY = 0;

        // Reset state
        repeat (3) @(posedge ACLK);
        @(negedge ACLK);
        check("rst_handshake_outs",
              {S_AXI_AWREADY, S_AXI_WREADY, S_AXI_ARREADY,
               S_AXI_BVALID, S_AXI_RVALID}, 5'b0);
        check("rst_resp", {S_AXI_BRESP, S_AXI_RRESP}, 4'b0);
        check("rst_rdata", S_AXI_RDATA, 32'h0);
        for (int i = 0; i < 4; i++) check("rst_ctrl", ctrl_regs[i], 32'h0);
        @(posedge ACLK); #1;
        ARESET = 0;
        check("ready_before_edge",
              {S_AXI_AWREADY, S_AXI_WREADY, S_AXI_ARREADY}, 3'b000);
        @(posedge ACLK); #1;
        check("ready_first_edge",
              {S_AXI_AWREADY, S_AXI_WREADY, S_AXI_ARREADY}, 3'b111);

        // Vector table
        for (int i = 0; i < 18; i++) begin
            if (vecs[i].is_wr) begin
                do_write(vecs[i].addr, vecs[i].data, vecs[i].strb, 0, resp, st);
                check($sformatf("vec%0d_bresp", i), resp, vecs[i].exp_resp);
            end else begin
                do_read(vecs[i].addr, 0, rdata, resp, st);
                check($sformatf("vec%0d_rdata", i), rdata, vecs[i].exp_rdata);
                check($sformatf("vec%0d_rresp", i), resp, vecs[i].exp_resp);
            end
            if (i == 3) begin
                for (int k = 0; k < 4; k++)
                    check($sformatf("ctrl%0d_after_writes", k),
                          ctrl_regs[k], 32'(k + 1));
            end
        end
        check("ctrl0_final", ctrl_regs[0], 32'h00FF00FF);
        check("ctrl1_final", ctrl_regs[1], 32'h2);
        check("ctrl2_final", ctrl_regs[2], 32'h3);
        check("ctrl3_final", ctrl_regs[3], 32'h44);

        // W three cycles ahead of AW
        @(negedge ACLK);
        S_AXI_WDATA = 32'hA5A5A5A5; S_AXI_WSTRB = 4'hF; S_AXI_WVALID = 1;
        S_AXI_AWADDR = 5'h04;
        @(posedge ACLK); #1;
        S_AXI_WVALID = 0;
        seen = 0;
        repeat (3) begin
            @(negedge ACLK);
            if (S_AXI_BVALID) seen = 1;
        end
        check("w_first_no_b", seen, 1'b0);
        check("w_first_readies", {S_AXI_WREADY, S_AXI_AWREADY}, 2'b01);
        check("w_first_ctrl1_untouched", ctrl_regs[1], 32'h2);
        S_AXI_AWVALID = 1;
        @(posedge ACLK); #1;
        S_AXI_AWVALID = 0;
        S_AXI_BREADY = 1;
        cnt = 0;
        repeat (6) begin
            @(negedge ACLK);
            if (S_AXI_BVALID) begin
                cnt++;
                check("w_first_bresp", S_AXI_BRESP, 2'b00);
            end
        end
        S_AXI_BREADY = 0;
        check("w_first_b_count", cnt, 1);
        check("w_first_ctrl1", ctrl_regs[1], 32'hA5A5A5A5);

        // Same-edge read and write of slot 0
        @(negedge ACLK);
        check("collide_readies",
              {S_AXI_AWREADY, S_AXI_WREADY, S_AXI_ARREADY}, 3'b111);
        S_AXI_AWADDR = 5'h00; S_AXI_AWVALID = 1;
        S_AXI_WDATA = 32'h11111111; S_AXI_WSTRB = 4'hF; S_AXI_WVALID = 1;
        S_AXI_ARADDR = 5'h00; S_AXI_ARVALID = 1;
        @(posedge ACLK); #1;
        S_AXI_AWVALID = 0; S_AXI_WVALID = 0; S_AXI_ARVALID = 0;
        S_AXI_BREADY = 1; S_AXI_RREADY = 1;
        @(negedge ACLK);
        check("collide_valids", {S_AXI_BVALID, S_AXI_RVALID}, 2'b11);
        check("collide_rdata_old", S_AXI_RDATA, 32'h00FF00FF);
        check("collide_ctrl0_new", ctrl_regs[0], 32'h11111111);
        @(posedge ACLK); #1;
        S_AXI_BREADY = 0; S_AXI_RREADY = 0;

        // Backpressure on B and R for 10 cycles
        do_write(5'h14, 32'h1234, 4'hF, 10, resp, st);
        check("bp_bresp", resp, 2'b10);
        check("bp_b_stable", st, 1'b1);
        fork
            do_read(5'h18, 10, rdata, resp, st);
            begin
                repeat (5) @(posedge ACLK);
                #2 status_in[2] = 32'h99999999;
            end
        join
        check("bp_rdata", rdata, 32'hCAFEF00D);
        check("bp_r_stable", st, 1'b1);

        // Reset while only W is held
        @(negedge ACLK);
        S_AXI_WDATA = 32'h77777777; S_AXI_WSTRB = 4'hF; S_AXI_WVALID = 1;
        check("rst_mid_wready", S_AXI_WREADY, 1'b1);
        @(posedge ACLK); #1;
        S_AXI_WVALID = 0;
        ARESET = 1;
        repeat (2) @(posedge ACLK);
        #1 ARESET = 0;
        @(negedge ACLK);
        for (int i = 0; i < 4; i++)
            check("rst_mid_ctrl", ctrl_regs[i], 32'h0);
        S_AXI_AWADDR = 5'h00; S_AXI_AWVALID = 1;
        S_AXI_BREADY = 1;
        seen = 0;
        cnt = 0;
        repeat (8) begin
            @(negedge ACLK);
            if (S_AXI_AWVALID && S_AXI_AWREADY) cnt++;
            if (S_AXI_BVALID) seen = 1;
            @(posedge ACLK); #1;
            if (cnt != 0) S_AXI_AWVALID = 0;
        end
        S_AXI_BREADY = 0;
        check("rst_mid_aw_taken", cnt, 1);
        check("rst_mid_no_b", seen, 1'b0);
        check("rst_mid_ctrl0", ctrl_regs[0], 32'h0);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end

endmodule
